seq_divider: RTL and testbench

//   Multi-cycle unsigned divider; inverse of the team's one-cycle multiplier.
//   - Divides a 2W-bit dividend by a W-bit divisor: W-bit quotient, W-bit remainder.
//   - Same req/rdy operand interface as the multiplier, so both share one ALU-side controller.
//   - Restoring algorithm, one quotient bit per clock.

---
 rtl/seq_divider.sv | 105 ++++++++++
 tb/tb_seq_divider.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: 2W-bit dividend / W-bit divisor -> W-bit q, r.
// One quotient bit per clock; b==0 and quotient overflow finish immediately.
module seq_divider #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic [2*W-1:0] a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           dz,
  output logic           ovf,
  output logic           rdy
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W:0]    pr;
  logic [W-1:0]  lo;
  logic [W-1:0]  qacc;
  logic [W-1:0]  dvs;

  logic [W:0]    diff;
  logic [W:0]    pr_nxt;
  logic          qbit;
  logic          special;
  logic          last;

  always_comb begin
    // pr always stays below dvs, so the trial difference fits in W+1 bits
    qbit    = ({pr, lo[W-1]} >= {2'b00, dvs});
    diff    = {pr[W-1:0], lo[W-1]} - {1'b0, dvs};
    pr_nxt  = qbit ? diff : {pr[W-1:0], lo[W-1]};
    special = (b == '0) || (a[2*W-1:W] >= b);
    last    = (cnt == CW'(W - 1));
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    case (state)
      IDLE: if (req) state_nxt = special ? DONE : RUN;
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        rdy       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pr    <= '0;
      lo    <= '0;
      qacc  <= '0;
      dvs   <= '0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req) begin
            dvs  <= b;
            lo   <= a[W-1:0];
            pr   <= {1'b0, a[2*W-1:W]};
            qacc <= '0;
            cnt  <= '0;
            if (special) begin
              q   <= '1;
              r   <= a[W-1:0];
              dz  <= (b == '0);
              ovf <= (b != '0);
            end
          end
        end
        RUN: begin
          pr   <= pr_nxt;
          lo   <= {lo[W-2:0], 1'b0};
          qacc <= {qacc[W-2:0], qbit};
          cnt  <= last ? '0 : cnt + 1'b1;
          if (last) begin
            q   <= {qacc[W-2:0], qbit};
            r   <= pr_nxt[W-1:0];
            dz  <= 1'b0;
            ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random bench for seq_divider; expected results queued at request,
// compared when rdy pulses.
module tb_seq_divider;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst, req;
  logic [2*W-1:0] a;
  logic [W-1:0]   b;
  logic [W-1:0]   q, r;
  logic           dz, ovf, rdy;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
  } res_t;

  res_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  seq_divider #(.W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b),
    .q(q), .r(r), .dz(dz), .ovf(ovf), .rdy(rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input logic [W-1:0] qv, input logic [W-1:0] rv,
                              input logic dzv, input logic ovfv);
    res_t e;
    e.q = qv; e.r = rv; e.dz = dzv; e.ovf = ovfv;
    return e;
  endfunction

  function automatic res_t model(input logic [2*W-1:0] av, input logic [W-1:0] bv);
    logic [2*W-1:0] qq, rr;
    if (bv == '0) return mk('1, av[W-1:0], 1'b1, 1'b0);
    if (av[2*W-1:W] >= bv) return mk('1, av[W-1:0], 1'b0, 1'b1);
    qq = av / {{W{1'b0}}, bv};
    rr = av % {{W{1'b0}}, bv};
    return mk(qq[W-1:0], rr[W-1:0], 1'b0, 1'b0);
  endfunction

  // Result checker: every rdy pulse must match the oldest queued expectation
  initial forever begin
    @(posedge clk); #1;
    if (rdy === 1'b1) begin
      if (sb.size() == 0) check("spurious_rdy", 64'd1, 64'd0);
      else begin
        res_t e;
        e = sb.pop_front();
        check("q", q, e.q);
        check("r", r, e.r);
        check("dz", dz, e.dz);
        check("ovf", ovf, e.ovf);
      end
    end
  end

  // Called #1 after an edge with the DUT idle; returns with the DUT idle again.
  // Latency counts edges from the accept edge (inclusive) until rdy is seen.
  task automatic run_op(input logic [2*W-1:0] av, input logic [W-1:0] bv,
                        input res_t e, input int lat, input string tag);
    int n;
    a = av; b = bv; req = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b0;
    a = {$urandom, $urandom};
    b = $urandom;
    n = 1;
    while (rdy !== 1'b1 && n < W + 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    int m, n;
    logic [2*W-1:0] av;
    logic [W-1:0]   bv, ahi;
    int kind;
    res_t e;

    rst = 1'b1; req = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_dz", dz, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rdy", rdy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(64'd100, 32'd7, mk(32'd14, 32'd2, 1'b0, 1'b0), W + 1, "t1");
    run_op(64'h0000_0000_FFFF_FFFF, 32'd1, mk(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0), W + 1, "t2a");
    run_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, mk(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0), W + 1, "t2b");
    run_op(64'h1234, 32'd0, mk(32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0), 1, "t3");
    run_op(64'h1_0000_0000, 32'd1, mk(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1), 1, "t4");

    // Abort: reset after ten RUN steps, no result may appear for this request
    a = 64'd1000; b = 32'd10; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_q", q, 0);
    check("abort_r", r, 0);
    check("abort_dz", dz, 0);
    check("abort_ovf", ovf, 0);
    check("abort_rdy", rdy, 0);
    repeat (W + 5) @(posedge clk);
    #1;
    run_op(64'd9, 32'd4, mk(32'd2, 32'd1, 1'b0, 1'b0), W + 1, "t5");

    // req held high with operands churning during RUN
    av = 64'h0000_0123_89AB_CDEF; bv = 32'h0001_0001;
    a = av; b = bv; req = 1'b1;
    sb.push_back(model(av, bv));
    @(posedge clk); #1;
    n = 1;
    while (rdy !== 1'b1 && n < W + 10) begin
      a = {$urandom, $urandom}; b = $urandom;
      @(posedge clk); #1;
      n++;
    end
    check("t6_lat", n, W + 1);
    av = 64'd123_456_789; bv = 32'd1000;
    a = av; b = bv;
    sb.push_back(mk(32'd123_456, 32'd789, 1'b0, 1'b0));
    m = 0;
    do begin
      @(posedge clk); #1;
      m++;
      if (m >= 2) begin
        req = 1'b0;
        a = {$urandom, $urandom}; b = $urandom;
      end
    end while (rdy !== 1'b1 && m < W + 12);
    check("t6_thruput", m, W + 2);
    @(posedge clk); #1;

    for (int i = 0; i < 1000; i++) begin
      kind = $urandom_range(15, 0);
      if (kind == 0) begin
        bv = '0;
        av = {$urandom, $urandom};
      end else if (kind == 1) begin
        bv = $urandom;
        if (bv == '0) bv = 32'd1;
        ahi = $urandom_range(32'hFFFF_FFFF, bv);
        av = {ahi, 32'($urandom)};
      end else begin
        bv = (kind < 6) ? 32'($urandom_range(255, 1)) : 32'($urandom);
        if (bv == '0) bv = 32'd1;
        ahi = $urandom_range(bv - 1, 0);
        av = {ahi, 32'($urandom)};
      end
      e = model(av, bv);
      run_op(av, bv, e, (e.dz || e.ovf) ? 1 : W + 1, "rnd");
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
